// File: rtl/regfile_read_bypass.sv
// regfile_read_bypass: merges same-edge register-file writes into returned read
// data, per byte, so ALU operands always see the architecturally newest value.
// An optional output stage re-applies the merge for writes landing one edge later.
`timescale 1ns/1ps
module regfile_read_bypass #(
    parameter int unsigned NUM_READ  = 8,
    parameter int unsigned NUM_WRITE = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned OUT_REG   = 0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_READ-1:0]               rd_valid,
    input  logic [NUM_READ*ADDR_W-1:0]        rd_addr,
    input  logic [NUM_READ*DATA_W-1:0]        rf_rd_data,
    input  logic [NUM_WRITE-1:0]              wr_en,
    input  logic [NUM_WRITE*ADDR_W-1:0]       wr_addr,
    input  logic [NUM_WRITE*DATA_W-1:0]       wr_data,
    input  logic [NUM_WRITE*(DATA_W/8)-1:0]   wr_mask,
    output logic [NUM_READ-1:0]               op_valid,
    output logic [NUM_READ*DATA_W-1:0]        op_data,
    output logic [NUM_READ-1:0]               fwd_hit
);

    localparam int unsigned NB = DATA_W / 8;

    // Bytes of register 'addr' covered by any enabled captured write.
    function automatic logic [NB-1:0] byte_hits(
        input logic [ADDR_W-1:0]           addr,
        input logic [NUM_WRITE-1:0]        en,
        input logic [NUM_WRITE*ADDR_W-1:0] waddr,
        input logic [NUM_WRITE*NB-1:0]     wmask
    );
        logic [NB-1:0] hits;
        hits = '0;
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (en[j] && (waddr[j*ADDR_W +: ADDR_W] == addr)) begin
                hits = hits | wmask[j*NB +: NB];
            end
        end
        return hits;
    endfunction

    // Overlay captured writes onto 'base'; ascending scan lets the highest write index win.
    function automatic logic [DATA_W-1:0] merge_data(
        input logic [ADDR_W-1:0]           addr,
        input logic [DATA_W-1:0]           base,
        input logic [NUM_WRITE-1:0]        en,
        input logic [NUM_WRITE*ADDR_W-1:0] waddr,
        input logic [NUM_WRITE*DATA_W-1:0] wdata,
        input logic [NUM_WRITE*NB-1:0]     wmask
    );
        logic [DATA_W-1:0] res;
        res = base;
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
            if (en[j] && (waddr[j*ADDR_W +: ADDR_W] == addr)) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (wmask[j*NB + b]) begin
                        res[b*8 +: 8] = wdata[j*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
        return res;
    endfunction

    // Stage-1 capture: read requests and the writes landing on the same edge.
    logic [NUM_READ-1:0]         s1_valid;
    logic [NUM_READ*ADDR_W-1:0]  s1_addr;
    logic [NUM_WRITE-1:0]        s1_wr_en;
    logic [NUM_WRITE*ADDR_W-1:0] s1_wr_addr;
    logic [NUM_WRITE*DATA_W-1:0] s1_wr_data;
    logic [NUM_WRITE*NB-1:0]     s1_wr_mask;

    // Stage-1 registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid   <= '0;
            s1_addr    <= '0;
            s1_wr_en   <= '0;
            s1_wr_addr <= '0;
            s1_wr_data <= '0;
            s1_wr_mask <= '0;
        end else begin
            s1_valid   <= rd_valid;
            s1_addr    <= rd_addr;
            s1_wr_en   <= wr_en;
            s1_wr_addr <= wr_addr;
            s1_wr_data <= wr_data;
            s1_wr_mask <= wr_mask;
        end
    end

    // Stage-1 merge of register-file data with the captured writes; zero when idle.
    logic [NUM_READ-1:0][DATA_W-1:0] m1_data;
    logic [NUM_READ-1:0]             m1_hit;

    always_comb begin
        m1_data = '0;
        m1_hit  = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            if (s1_valid[i]) begin
                m1_data[i] = merge_data(s1_addr[i*ADDR_W +: ADDR_W], rf_rd_data[i*DATA_W +: DATA_W],
                                        s1_wr_en, s1_wr_addr, s1_wr_data, s1_wr_mask);
                m1_hit[i]  = |byte_hits(s1_addr[i*ADDR_W +: ADDR_W],
                                        s1_wr_en, s1_wr_addr, s1_wr_mask);
            end
        end
    end

    generate
        if (OUT_REG == 0) begin : g_direct
            // Forwarded result leaves in the cycle after the request; reset blanks it at once.
            always_comb begin
                op_valid = s1_valid & {NUM_READ{~reset}};
                fwd_hit  = m1_hit & {NUM_READ{~reset}};
                op_data  = reset ? '0 : m1_data;
            end
        end else begin : g_staged
            logic [NUM_READ-1:0]             s2_valid;
            logic [NUM_READ*ADDR_W-1:0]      s2_addr;
            logic [NUM_READ-1:0][DATA_W-1:0] s2_data;
            logic [NUM_READ-1:0]             s2_hit;
            logic [NUM_READ-1:0][DATA_W-1:0] m2_data;
            logic [NUM_READ-1:0]             m2_hit;

            // Stage-2 registers holding the stage-1 merged operand.
            always_ff @(posedge clock) begin
                if (reset) begin
                    s2_valid <= '0;
                    s2_addr  <= '0;
                    s2_data  <= '0;
                    s2_hit   <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_addr  <= s1_addr;
                    s2_data  <= m1_data;
                    s2_hit   <= m1_hit;
                end
            end

            // Stage-2 merge: the stage-1 write capture now holds the writes of the following edge.
            always_comb begin
                m2_data = '0;
                m2_hit  = '0;
                for (int unsigned i = 0; i < NUM_READ; i++) begin
                    if (s2_valid[i]) begin
                        m2_data[i] = merge_data(s2_addr[i*ADDR_W +: ADDR_W], s2_data[i],
                                                s1_wr_en, s1_wr_addr, s1_wr_data, s1_wr_mask);
                        m2_hit[i]  = s2_hit[i] | (|byte_hits(s2_addr[i*ADDR_W +: ADDR_W],
                                                             s1_wr_en, s1_wr_addr, s1_wr_mask));
                    end
                end
            end

            // Output drive; reset blanks it at once.
            always_comb begin
                op_valid = s2_valid & {NUM_READ{~reset}};
                fwd_hit  = m2_hit & {NUM_READ{~reset}};
                op_data  = reset ? '0 : m2_data;
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_read_bypass.sv
// Bench for regfile_read_bypass: one instance per OUT_REG setting, shared stimulus,
// a register-file reference model plus hand-computed directed vectors.
`timescale 1ns/1ps
module tb_regfile_read_bypass;

    localparam int unsigned NR = 8;
    localparam int unsigned NW = 8;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 64;
    localparam int unsigned NB = DW / 8;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     rd_valid;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rf_rd_data;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NW*NB-1:0]  wr_mask;
    logic [NR-1:0]     op_valid0, fwd_hit0, op_valid1, fwd_hit1;
    logic [NR*DW-1:0]  op_data0, op_data1;

    regfile_read_bypass #(.NUM_READ(NR), .NUM_WRITE(NW), .ADDR_W(AW), .DATA_W(DW), .OUT_REG(0)) u_dut0 (
        .clock(clock), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr), .rf_rd_data(rf_rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .op_valid(op_valid0), .op_data(op_data0), .fwd_hit(fwd_hit0));

    regfile_read_bypass #(.NUM_READ(NR), .NUM_WRITE(NW), .ADDR_W(AW), .DATA_W(DW), .OUT_REG(1)) u_dut1 (
        .clock(clock), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr), .rf_rd_data(rf_rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .op_valid(op_valid1), .op_data(op_data1), .fwd_hit(fwd_hit1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference register file and expected-output pipeline.
    logic [DW-1:0] rf_model [32];
    logic [NR-1:0] e0_valid, e0_hit, e1_valid, e1_hit, q1_valid, q1_hit;
    logic [DW-1:0] e0_data [NR];
    logic [DW-1:0] e1_data [NR];
    logic [AW-1:0] q1_addr [NR];

    function automatic logic wr_hits(input logic [AW-1:0] a);
        logic h;
        h = 1'b0;
        for (int j = 0; j < NW; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == a && wr_mask[j*NB +: NB] != '0) h = 1'b1;
        return h;
    endfunction

    task automatic check_outputs();
        logic ev;
        for (int i = 0; i < NR; i++) begin
            ev = e0_valid[i] && !reset;
            check_eq($sformatf("v0[%0d]", i), 64'(op_valid0[i]), 64'(ev));
            check_eq($sformatf("d0[%0d]", i), op_data0[i*DW +: DW], ev ? e0_data[i] : 64'd0);
            check_eq($sformatf("h0[%0d]", i), 64'(fwd_hit0[i]), 64'(ev && e0_hit[i]));
            ev = e1_valid[i] && !reset;
            check_eq($sformatf("v1[%0d]", i), 64'(op_valid1[i]), 64'(ev));
            check_eq($sformatf("d1[%0d]", i), op_data1[i*DW +: DW], ev ? e1_data[i] : 64'd0);
            check_eq($sformatf("h1[%0d]", i), 64'(fwd_hit1[i]), 64'(ev && e1_hit[i]));
        end
    endtask

    // One clock: model the register file, present its old read data, check at negedge.
    task automatic step();
        logic [DW-1:0] snap [NR];
        logic [NR-1:0] h_new, h_q1;
        logic [AW-1:0] a;
        for (int i = 0; i < NR; i++) begin
            snap[i]  = rf_model[rd_addr[i*AW +: AW]];
            h_new[i] = wr_hits(rd_addr[i*AW +: AW]);
            h_q1[i]  = wr_hits(q1_addr[i]);
        end
        @(posedge clock);
        for (int j = 0; j < NW; j++) begin
            if (wr_en[j]) begin
                a = wr_addr[j*AW +: AW];
                for (int b = 0; b < NB; b++)
                    if (wr_mask[j*NB + b]) rf_model[a][b*8 +: 8] = wr_data[j*DW + b*8 +: 8];
            end
        end
        if (reset) begin
            e0_valid = '0; e1_valid = '0; q1_valid = '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                e1_valid[i] = q1_valid[i];
                e1_data[i]  = rf_model[q1_addr[i]];
                e1_hit[i]   = q1_hit[i] | h_q1[i];
                e0_valid[i] = rd_valid[i];
                e0_data[i]  = rf_model[rd_addr[i*AW +: AW]];
                e0_hit[i]   = h_new[i];
                q1_valid[i] = rd_valid[i];
                q1_addr[i]  = rd_addr[i*AW +: AW];
                q1_hit[i]   = h_new[i];
            end
        end
        #1;
        for (int i = 0; i < NR; i++) rf_rd_data[i*DW +: DW] = snap[i];
        @(negedge clock);
        check_outputs();
    endtask

    task automatic set_rd(input int port, input logic [AW-1:0] a);
        rd_valid[port] = 1'b1;
        rd_addr[port*AW +: AW] = a;
    endtask

    task automatic set_wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
        wr_en[port] = 1'b1;
        wr_addr[port*AW +: AW] = a;
        wr_data[port*DW +: DW] = d;
        wr_mask[port*NB +: NB] = m;
    endtask

    initial begin
        reset = 1'b1; rd_valid = '1; wr_en = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rf_rd_data = '0;
        for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
        for (int r = 0; r < 32; r++) rf_model[r] = '0;
        e0_valid = '0; e1_valid = '0; q1_valid = '0; e0_hit = '0; e1_hit = '0; q1_hit = '0;
        for (int i = 0; i < NR; i++) begin
            e0_data[i] = '0; e1_data[i] = '0; q1_addr[i] = '0;
        end

        // Reset held three cycles with all reads requested.
        repeat (3) step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) begin
            check_eq("rel_v0", 64'(op_valid0[i]), 64'd0);
            check_eq("rel_v1", 64'(op_valid1[i]), 64'd0);
            check_eq("rel_d0", op_data0[i*DW +: DW], 64'd0);
            check_eq("rel_h0", 64'(fwd_hit0[i]), 64'd0);
        end
        rd_valid = '0;
        step();

        // No hazard.
        rf_model[5] = 64'h1122334455667788;
        set_rd(0, 5'd5);
        step();
        check_eq("nohaz_d0", op_data0[0 +: DW], 64'h1122334455667788);
        check_eq("nohaz_v0", 64'(op_valid0[0]), 64'd1);
        check_eq("nohaz_h0", 64'(fwd_hit0[0]), 64'd0);
        rd_valid = '0;
        step();
        check_eq("nohaz_d1", op_data1[0 +: DW], 64'h1122334455667788);
        check_eq("nohaz_v1", 64'(op_valid1[0]), 64'd1);

        // Same-edge partial write.
        rf_model[7] = 64'h0;
        set_rd(0, 5'd7);
        set_wr(2, 5'd7, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        step();
        check_eq("part_d0", op_data0[0 +: DW], 64'h00000000AAAAAAAA);
        check_eq("part_h0", 64'(fwd_hit0[0]), 64'd1);
        rd_valid = '0; wr_en = '0;
        step();
        check_eq("part_d1", op_data1[0 +: DW], 64'h00000000AAAAAAAA);

        // Write priority, two readers of the same register.
        rf_model[3] = 64'hDEADBEEF00000000;
        set_rd(0, 5'd3);
        set_rd(4, 5'd3);
        set_wr(1, 5'd3, 64'h1, 8'hFF);
        set_wr(6, 5'd3, 64'h6, 8'hFF);
        step();
        check_eq("prio_d0p0", op_data0[0 +: DW], 64'h6);
        check_eq("prio_d0p4", op_data0[4*DW +: DW], 64'h6);
        rd_valid = '0; wr_en = '0;
        step();
        check_eq("prio_d1p4", op_data1[4*DW +: DW], 64'h6);

        // Enabled write with an empty mask forwards nothing.
        rf_model[12] = 64'h0123456789ABCDEF;
        set_rd(3, 5'd12);
        set_wr(5, 5'd12, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        step();
        check_eq("zmask_d0", op_data0[3*DW +: DW], 64'h0123456789ABCDEF);
        check_eq("zmask_h0", 64'(fwd_hit0[3]), 64'd0);
        rd_valid = '0; wr_en = '0;
        step();

        // Second-stage forward for the registered output.
        rf_model[9] = 64'h10;
        set_rd(0, 5'd9);
        step();
        rd_valid = '0;
        set_wr(0, 5'd9, 64'hFFFFFFFFFFFFFFFF, 8'h80);
        step();
        check_eq("s2_d1", op_data1[0 +: DW], 64'hFF00000000000010);
        check_eq("s2_h1", 64'(fwd_hit1[0]), 64'd1);
        check_eq("s2_v1", 64'(op_valid1[0]), 64'd1);
        wr_en = '0;
        step();

        // Streaming with random colliding writes, reset in cycle 10.
        for (int c = 0; c < 20; c++) begin
            rd_valid = '1;
            for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            for (int j = 0; j < NW; j++) begin
                wr_en[j] = 1'($urandom_range(0, 1));
                wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
                wr_data[j*DW +: DW] = {$urandom, $urandom};
                wr_mask[j*NB +: NB] = NB'($urandom_range(0, 255));
            end
            if (c == 10) begin
                reset = 1'b1;
                #1;
                check_eq("rst_v0", 64'(op_valid0), 64'd0);
                check_eq("rst_v1", 64'(op_valid1), 64'd0);
            end
            step();
            reset = 1'b0;
        end
        rd_valid = '0; wr_en = '0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_read_bypass.md
Name: regfile_read_bypass

Overview:
- Sits directly downstream of the 32x64, 8-read/8-write register file, between its read-data outputs and the ALU operand inputs.
- The register file returns read data one cycle after the address is presented. That data reflects only writes committed before the address edge. Writes landing on that same edge are not visible (read-under-write returns old data).
- This block merges those same-edge writes into the returned data, per byte. It can optionally add one output pipeline stage, which is also forwarded. Consumers always see the architecturally newest value.

Parameters:
- NUM_READ, 8, number of read ports handled
- NUM_WRITE, 8, number of write ports snooped
- ADDR_W, 5, register address width
- DATA_W, 64, data width; must be a multiple of 8
- OUT_REG, 0, 0 = forwarded data valid at T+1; 1 = extra registered stage, valid at T+2

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- rd_valid  in  NUM_READ  read request valid per port, same cycle as the address sent to the register file
- rd_addr  in  NUM_READ*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rf_rd_data  in  NUM_READ*DATA_W  register file read data, arriving one cycle after rd_addr
- wr_en  in  NUM_WRITE  write enables, identical to those driven into the register file
- wr_addr  in  NUM_WRITE*ADDR_W  write addresses
- wr_data  in  NUM_WRITE*DATA_W  write values
- wr_mask  in  NUM_WRITE*(DATA_W/8)  byte masks, bit b covers byte b
- op_valid  out  NUM_READ  forwarded operand valid per port
- op_data  out  NUM_READ*DATA_W  forwarded operand data
- fwd_hit  out  NUM_READ  at least one byte of op_data came from a bypassed write (debug/perf)

Behaviour:
- Reset: all internal state cleared. op_valid=0, fwd_hit=0, op_data=0 on the first cycle after reset high. Reset mid-operation drops in-flight requests; no stale valid after deassert.
- Stage 1 (edge T): register rd_valid/rd_addr per port. Also register wr_en/wr_addr/wr_data/wr_mask for all write ports (the same-edge writes).
- Stage 1 merge (cycle T+1): per read port i, per byte b, a candidate is write port j with captured wr_en, wr_addr==captured rd_addr, and mask bit b set.
  - Byte b = wr_data byte of the highest-index matching j.
  - No candidate: byte b = rf_rd_data byte.
  - This matches register file write priority: higher write index wins on the same address and byte.
- fwd_hit[i] = OR over all bytes of "candidate existed" AND the captured valid.
- OUT_REG=0: op_* driven combinationally from the stage-1 merge at T+1. No extra cycle.
- OUT_REG=1:
  - Merged result, valid and address registered at edge T+1.
  - Writes landing at edge T+1 are merged into the registered value during cycle T+2, using the same byte/priority rule.
  - op_* valid at T+2. fwd_hit covers both stages.
- op_valid[i] = captured rd_valid[i] (delayed per OUT_REG). When op_valid=0, op_data is don't-care but must hold a deterministic value: zero is acceptable.
- Masks: wr_en=1 with an all-zero mask forwards nothing. A partial mask merges only the selected bytes; remaining bytes come from the older value.
- Read ports are fully independent. Multiple read ports to the same address each get an identical merge.
- No backpressure. Every valid read produces exactly one op_valid pulse, at fixed latency 1+OUT_REG.
- Throughput: one request per port per cycle, back-to-back, no bubbles.
- Address 0 has no special behaviour.

Test Plan:
- Reset: hold reset 3 cycles with rd_valid=all-ones -> op_valid=0, op_data=0, fwd_hit=0 throughout and on the first cycle after release.
- No hazard, OUT_REG=0: rd_addr[0]=5 at T, no writes, rf_rd_data[0]=0x1122334455667788 at T+1 -> op_data[0]=0x1122334455667788, op_valid[0]=1, fwd_hit[0]=0 at T+1.
- Same-edge partial write: at T, read r7 plus write port 2 addr=7, data=0xAAAAAAAAAAAAAAAA, mask=0x0F; rf_rd_data=0x0 -> op_data=0x00000000AAAAAAAA, fwd_hit=1.
- Priority: at T, write ports 1 and 6 both hit addr 3 with full mask, data 0x1 and 0x6 -> op_data for a read of r3 = 0x6.
- OUT_REG=1 second-stage forward: read r9 at T, rf data 0x10; write r9=0xFF, mask=0x80 at edge T+1 -> op_data=0xFF00000000000010 at T+2, fwd_hit=1.
- Streaming plus reset: all 8 ports read back-to-back for 20 cycles against a reference-model register file with random writes -> every op_data matches the model. Assert reset in cycle 10 -> no op_valid for requests issued at or before reset.
